// File: rtl/tm_sequencer.sv
// Purpose: front-end controller for the Turing machine datapath. It turns the Next/Done
//          levels into edge events, sequences rule entry, tape entry and single-step run,
//          and drives the rule/tape write ports and the step_req/step_ack handshake.
// Latency: every output is registered. A strobe or step_req appears one cycle after the
//          clock edge that sampled the causing event.
// Backpressure: none. Next in RUN/BUSY and in HALT is dropped, not queued. Next events
//          after the rule table is full are ignored. The tape pointer saturates on the last cell.
// Ports: clock/reset (sync, active-high); input_data/Next/Done user inputs;
//        rule_we/rule_addr/rule_wdata and tape_we/tape_addr/tape_wdata memory write ports;
//        step_req/step_ack/halted datapath handshake; phase/rule_count/Compute_done status.
module tm_sequencer #(
    parameter int DW       = 6,
    parameter int NRULES   = 16,
    parameter int TAPE_LEN = 64,
    parameter int FIELDS   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DW-1:0]               input_data,
    input  logic                        Next,
    input  logic                        Done,
    output logic                        rule_we,
    output logic [$clog2(NRULES)-1:0]   rule_addr,
    output logic [FIELDS*DW-1:0]        rule_wdata,
    output logic                        tape_we,
    output logic [$clog2(TAPE_LEN)-1:0] tape_addr,
    output logic [DW-1:0]               tape_wdata,
    output logic                        step_req,
    input  logic                        step_ack,
    input  logic                        halted,
    output logic [1:0]                  phase,
    output logic [$clog2(NRULES):0]     rule_count,
    output logic                        Compute_done
);

    localparam int RAW = $clog2(NRULES);
    localparam int TAW = $clog2(TAPE_LEN);
    localparam int RCW = $clog2(NRULES) + 1;
    localparam int IW  = (FIELDS > 1) ? $clog2(FIELDS) : 1;

    localparam logic [RCW-1:0] RULES_FULL = RCW'(NRULES);
    localparam logic [TAW-1:0] TAPE_LAST  = TAW'(TAPE_LEN - 1);
    localparam logic [IW-1:0]  FIELD_LAST = IW'(FIELDS - 1);

    typedef enum logic [1:0] {
        PH_RULES = 2'd0,
        PH_TAPE  = 2'd1,
        PH_RUN   = 2'd2,
        PH_HALT  = 2'd3
    } phase_t;

    typedef enum logic {
        RUN_IDLE = 1'b0,
        RUN_BUSY = 1'b1
    } run_t;

    phase_t                 phase_q, phase_d;
    run_t                   run_q, run_d;
    logic                   next_q, done_q;
    logic [IW-1:0]          idx_q, idx_d;
    logic [FIELDS*DW-1:0]   asm_q, asm_d;
    logic [RCW-1:0]         rule_count_q, rule_count_d;
    logic [TAW-1:0]         tape_ptr_q, tape_ptr_d;
    logic                   rule_we_q, rule_we_d;
    logic [RAW-1:0]         rule_addr_q, rule_addr_d;
    logic [FIELDS*DW-1:0]   rule_wdata_q, rule_wdata_d;
    logic                   tape_we_q, tape_we_d;
    logic [TAW-1:0]         tape_addr_q, tape_addr_d;
    logic [DW-1:0]          tape_wdata_q, tape_wdata_d;
    logic                   step_req_q, step_req_d;
    logic                   compute_done_q, compute_done_d;

    logic next_ev, done_ev;

    // A Done edge takes priority: when both edges arrive together, the Next edge is dropped.
    assign done_ev = Done & ~done_q;
    assign next_ev = Next & ~next_q & ~done_ev;

    always_comb begin
        phase_d        = phase_q;
        run_d          = run_q;
        idx_d          = idx_q;
        asm_d          = asm_q;
        rule_count_d   = rule_count_q;
        tape_ptr_d     = tape_ptr_q;
        rule_we_d      = 1'b0;
        rule_addr_d    = rule_addr_q;
        rule_wdata_d   = rule_wdata_q;
        tape_we_d      = 1'b0;
        tape_addr_d    = tape_addr_q;
        tape_wdata_d   = tape_wdata_q;
        step_req_d     = step_req_q;

        unique case (phase_q)
            PH_RULES: begin
                if (done_ev) begin
                    // Any partially assembled rule is dropped.
                    phase_d = PH_TAPE;
                    idx_d   = '0;
                    asm_d   = '0;
                end else if (next_ev && (rule_count_q != RULES_FULL)) begin
                    // Field 0 is placed in the MSBs of the assembled word.
                    for (int f = 0; f < FIELDS; f++) begin
                        if (idx_q == IW'(f)) begin
                            asm_d[(FIELDS-1-f)*DW +: DW] = input_data;
                        end
                    end
                    if (idx_q == FIELD_LAST) begin
                        rule_we_d    = 1'b1;
                        rule_addr_d  = rule_count_q[RAW-1:0];
                        rule_wdata_d = asm_d;
                        rule_count_d = rule_count_q + 1'b1;
                        idx_d        = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PH_TAPE: begin
                if (done_ev) begin
                    phase_d = PH_RUN;
                    run_d   = RUN_IDLE;
                end else if (next_ev) begin
                    tape_we_d    = 1'b1;
                    tape_addr_d  = tape_ptr_q;
                    tape_wdata_d = input_data;
                    // The pointer sticks on the last cell, so later symbols overwrite it.
                    if (tape_ptr_q != TAPE_LAST) begin
                        tape_ptr_d = tape_ptr_q + 1'b1;
                    end
                end
            end
            PH_RUN: begin
                if (run_q == RUN_IDLE) begin
                    if (halted) begin
                        phase_d = PH_HALT;
                    end else if (next_ev) begin
                        step_req_d = 1'b1;
                        run_d      = RUN_BUSY;
                    end
                end else if (step_ack) begin
                    step_req_d = 1'b0;
                    run_d      = RUN_IDLE;
                    if (halted) begin
                        phase_d = PH_HALT;
                    end
                end
            end
            PH_HALT: begin
                if (done_ev) begin
                    phase_d      = PH_RULES;
                    run_d        = RUN_IDLE;
                    idx_d        = '0;
                    asm_d        = '0;
                    rule_count_d = '0;
                    tape_ptr_d   = '0;
                    rule_addr_d  = '0;
                    rule_wdata_d = '0;
                    tape_addr_d  = '0;
                    tape_wdata_d = '0;
                    step_req_d   = 1'b0;
                end
            end
            default: phase_d = PH_RULES;
        endcase

        compute_done_d = (phase_d == PH_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // The edge registers start high so that a button held through reset gives no event.
            next_q         <= 1'b1;
            done_q         <= 1'b1;
            phase_q        <= PH_RULES;
            run_q          <= RUN_IDLE;
            idx_q          <= '0;
            asm_q          <= '0;
            rule_count_q   <= '0;
            tape_ptr_q     <= '0;
            rule_we_q      <= 1'b0;
            rule_addr_q    <= '0;
            rule_wdata_q   <= '0;
            tape_we_q      <= 1'b0;
            tape_addr_q    <= '0;
            tape_wdata_q   <= '0;
            step_req_q     <= 1'b0;
            compute_done_q <= 1'b0;
        end else begin
            next_q         <= Next;
            done_q         <= Done;
            phase_q        <= phase_d;
            run_q          <= run_d;
            idx_q          <= idx_d;
            asm_q          <= asm_d;
            rule_count_q   <= rule_count_d;
            tape_ptr_q     <= tape_ptr_d;
            rule_we_q      <= rule_we_d;
            rule_addr_q    <= rule_addr_d;
            rule_wdata_q   <= rule_wdata_d;
            tape_we_q      <= tape_we_d;
            tape_addr_q    <= tape_addr_d;
            tape_wdata_q   <= tape_wdata_d;
            step_req_q     <= step_req_d;
            compute_done_q <= compute_done_d;
        end
    end

    assign rule_we      = rule_we_q;
    assign rule_addr    = rule_addr_q;
    assign rule_wdata   = rule_wdata_q;
    assign tape_we      = tape_we_q;
    assign tape_addr    = tape_addr_q;
    assign tape_wdata   = tape_wdata_q;
    assign step_req     = step_req_q;
    assign phase        = phase_q;
    assign rule_count   = rule_count_q;
    assign Compute_done = compute_done_q;

endmodule

// File: tb/tb_tm_sequencer.sv
// Purpose: testbench for tm_sequencer. Random stimulus is applied, and a queue-based
//          reference model checks the memory write strobes, the step handshake and the status outputs.
// Latency: the bench expects each strobe one cycle after the event edge. It expects step_req
//          to stay high for exactly the acknowledge delay that the datapath responder applies.
// Backpressure: a responder process models the datapath and pulses step_ack after a delay that the bench chooses.
module tb_tm_sequencer;

    localparam int DW       = 6;
    localparam int NRULES   = 16;
    localparam int TAPE_LEN = 64;
    localparam int FIELDS   = 4;
    localparam int RAW      = $clog2(NRULES);
    localparam int TAW      = $clog2(TAPE_LEN);

    logic                 clock = 1'b0;
    logic                 reset;
    logic [DW-1:0]        input_data;
    logic                 Next;
    logic                 Done;
    logic                 rule_we;
    logic [RAW-1:0]       rule_addr;
    logic [FIELDS*DW-1:0] rule_wdata;
    logic                 tape_we;
    logic [TAW-1:0]       tape_addr;
    logic [DW-1:0]        tape_wdata;
    logic                 step_req;
    logic                 step_ack;
    logic                 halted;
    logic [1:0]           phase;
    logic [RAW:0]         rule_count;
    logic                 Compute_done;

    tm_sequencer #(.DW(DW), .NRULES(NRULES), .TAPE_LEN(TAPE_LEN), .FIELDS(FIELDS)) dut (
        .clock(clock), .reset(reset), .input_data(input_data), .Next(Next), .Done(Done),
        .rule_we(rule_we), .rule_addr(rule_addr), .rule_wdata(rule_wdata),
        .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
        .step_req(step_req), .step_ack(step_ack), .halted(halted),
        .phase(phase), .rule_count(rule_count), .Compute_done(Compute_done)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the user-visible machine state, tracked at the level of events.
    int             m_phase = 0;
    int             m_count = 0;
    int             m_ptr   = 0;
    bit             m_busy  = 0;
    logic [DW-1:0]  m_fields[$];

    // Scoreboard queues for the expected strobes and step lengths.
    int                   exp_raddr[$];
    logic [FIELDS*DW-1:0] exp_rdata[$];
    int                   exp_taddr[$];
    logic [DW-1:0]        exp_tdata[$];
    int                   exp_step[$];

    int                   ack_delay   = 3;
    bit                   halt_on_ack = 0;
    bit                   stim_halt   = 0;
    int                   acks_done   = 0;
    logic [FIELDS*DW-1:0] last_rdata  = '0;

    assign halted = stim_halt | (step_ack & halt_on_ack);

    function automatic void model_next(input logic [DW-1:0] d);
        logic [FIELDS*DW-1:0] w;
        case (m_phase)
            0: if (m_count < NRULES) begin
                m_fields.push_back(d);
                if (m_fields.size() == FIELDS) begin
                    w = '0;
                    foreach (m_fields[i]) w = (w << DW) | (FIELDS*DW)'(m_fields[i]);
                    exp_raddr.push_back(m_count);
                    exp_rdata.push_back(w);
                    m_count++;
                    m_fields.delete();
                end
            end
            1: begin
                exp_taddr.push_back(m_ptr);
                exp_tdata.push_back(d);
                if (m_ptr < TAPE_LEN - 1) m_ptr++;
            end
            2: if (!m_busy) begin
                m_busy = 1;
                exp_step.push_back(ack_delay);
            end
            default: ;
        endcase
    endfunction

    function automatic void model_done();
        case (m_phase)
            0: begin m_phase = 1; m_fields.delete(); end
            1: begin m_phase = 2; m_busy = 0; end
            3: begin m_phase = 0; m_count = 0; m_ptr = 0; m_fields.delete(); end
            default: ;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One press lasts two cycles. The event edge is the first posedge that samples the inputs high.
    task automatic press(input bit nx, input bit dn, input logic [DW-1:0] d);
        @(posedge clock); #1;
        input_data = d;
        Next       = nx;
        Done       = dn;
        if (dn)      model_done();
        else if (nx) model_next(d);
        @(posedge clock); #1;
        Next = 1'b0;
        Done = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom_range(0, (1 << DW) - 1));
    endfunction

    task automatic do_step(input int dly, input bit hlt, input bit extra);
        int start;
        start       = acks_done;
        ack_delay   = dly;
        halt_on_ack = hlt;
        press(1'b1, 1'b0, rnd());
        if (extra) press(1'b1, 1'b0, rnd());
        for (int t = 0; t < 60 && acks_done == start; t++) @(posedge clock);
        #1;
        chk("step_ack_issued", 64'(acks_done != start), 64'd1);
        m_busy = 0;
        if (hlt) m_phase = 3;
        idle(2);
    endtask

    task automatic check_status(input string tag);
        idle(3);
        chk({tag, "_phase"}, 64'(phase), 64'(m_phase));
        chk({tag, "_rule_count"}, 64'(rule_count), 64'(m_count));
        chk({tag, "_compute_done"}, 64'(Compute_done), 64'(m_phase == 3));
    endtask

    // Datapath responder: once it sees step_req, it acknowledges so that step_req stays high ack_delay cycles.
    initial begin
        step_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (step_req === 1'b1 && reset === 1'b0) begin
                repeat (ack_delay - 1) @(posedge clock);
                #1 step_ack = 1'b1;
                @(posedge clock);
                #1 step_ack = 1'b0;
                acks_done++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or ends a step request.
    initial begin
        bit in_step;
        int step_len;
        in_step  = 0;
        step_len = 0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b0) continue;
            if (rule_we === 1'b1) begin
                if (exp_raddr.size() == 0) chk("rule_we_spurious", 64'd1, 64'd0);
                else begin
                    chk("rule_addr", 64'(rule_addr), 64'(exp_raddr.pop_front()));
                    chk("rule_wdata", 64'(rule_wdata), 64'(exp_rdata.pop_front()));
                    last_rdata = rule_wdata;
                end
            end
            if (tape_we === 1'b1) begin
                if (exp_taddr.size() == 0) chk("tape_we_spurious", 64'd1, 64'd0);
                else begin
                    chk("tape_addr", 64'(tape_addr), 64'(exp_taddr.pop_front()));
                    chk("tape_wdata", 64'(tape_wdata), 64'(exp_tdata.pop_front()));
                end
            end
            if (step_req === 1'b1) begin
                in_step  = 1;
                step_len = step_len + 1;
            end else if (in_step) begin
                if (exp_step.size() == 0) chk("step_req_spurious", 64'd1, 64'd0);
                else chk("step_req_cycles", 64'(step_len), 64'(exp_step.pop_front()));
                in_step  = 0;
                step_len = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        Next       = 1'b1;
        Done       = 1'b0;
        input_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        // Next is still held high after reset: this must not give an event.
        idle(3);
        chk("reset_rule_we", 64'(rule_we), 64'd0);
        chk("reset_tape_we", 64'(tape_we), 64'd0);
        chk("reset_step_req", 64'(step_req), 64'd0);
        check_status("reset");
        Next = 1'b0;

        // First rule: 3,1,1,2.
        press(1'b1, 1'b0, 6'd3);
        press(1'b1, 1'b0, 6'd1);
        press(1'b1, 1'b0, 6'd1);
        press(1'b1, 1'b0, 6'd2);
        check_status("rule0");
        chk("rule0_word", 64'(last_rdata), 64'h0C1042);

        // Four more random rules, then a partial rule, then Done.
        for (int r = 0; r < 4; r++)
            for (int f = 0; f < FIELDS; f++) begin
                press(1'b1, 1'b0, rnd());
                idle($urandom_range(0, 2));
            end
        press(1'b1, 1'b0, rnd());
        press(1'b1, 1'b0, rnd());
        press(1'b0, 1'b1, '0);
        check_status("rules_done");

        // Tape entry, then RUN.
        press(1'b1, 1'b0, 6'd32);
        press(1'b1, 1'b0, 6'd0);
        press(1'b0, 1'b1, '0);
        check_status("tape_done");

        // The first step has a 3-cycle ack and a second Next while busy. Then random steps, and the last one halts.
        do_step(3, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) do_step($urandom_range(1, 5), 1'b0, 1'b0);
        do_step($urandom_range(1, 4), 1'b1, 1'b0);
        check_status("halted");

        // HALT ignores Next. Done returns to RULES with all state cleared.
        press(1'b1, 1'b0, rnd());
        check_status("halt_next");
        press(1'b0, 1'b1, '0);
        check_status("halt_done");

        // Next and Done together: Done wins, so the partial rule is not completed.
        press(1'b1, 1'b0, rnd());
        press(1'b1, 1'b0, rnd());
        press(1'b1, 1'b0, rnd());
        press(1'b1, 1'b1, rnd());
        check_status("both_edges");

        // Tape pointer saturation: 66 symbols, and the last three land on cell 63.
        for (int i = 0; i < TAPE_LEN + 2; i++) press(1'b1, 1'b0, rnd());
        press(1'b0, 1'b1, '0);
        do_step($urandom_range(1, 5), 1'b0, 1'b0);
        // halted while idle in RUN stops without a step.
        stim_halt = 1'b1;
        idle(3);
        m_phase = 3;
        check_status("idle_halt");
        press(1'b0, 1'b1, '0);
        stim_halt = 1'b0;
        check_status("second_reset");

        // Rule table saturation: the 17th rule is ignored.
        for (int r = 0; r < NRULES + 1; r++)
            for (int f = 0; f < FIELDS; f++) press(1'b1, 1'b0, rnd());
        check_status("rules_full");
        press(1'b0, 1'b1, '0);
        check_status("rules_full_done");

        idle(4);
        chk("rule_queue_empty", 64'(exp_raddr.size()), 64'd0);
        chk("tape_queue_empty", 64'(exp_taddr.size()), 64'd0);
        chk("step_queue_empty", 64'(exp_step.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
